// File: rtl/rx_detection_report_fifo.sv
// Detection report FIFO: edge-detects upstream triggers, rejects weak peaks, tags and buffers
// results for the ARM bridge, and keeps overflow/drop/reject status.
module rx_detection_report_fifo #(
  parameter int unsigned        DEPTH    = 4,
  parameter logic signed [40:0] MIN_PEAK = 41'sd0
) (
  input  logic               crx_clk,
  input  logic               rrx_rst_n,
  input  logic               erx_en,
  input  logic signed [40:0] ipeak,
  input  logic        [3:0]  iseq,
  input  logic        [15:0] itime,
  input  logic               itrigger,
  input  logic               iready,
  input  logic               iclear_status,
  output logic               o_valid,
  output logic signed [40:0] o_peak,
  output logic        [3:0]  o_seq,
  output logic        [15:0] o_time,
  output logic        [7:0]  o_tag,
  output logic        [3:0]  o_level,
  output logic               o_overflow,
  output logic        [7:0]  o_drop_count,
  output logic        [7:0]  o_reject_count
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef struct packed {
    logic signed [40:0] peak;
    logic        [3:0]  seq;
    logic        [15:0] tim;
    logic        [7:0]  tag;
  } rec_t;

  rec_t            mem_q [DEPTH];
  rec_t            mem_d [DEPTH];
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [3:0]      level_q, level_d;
  logic            rtrig_q, rtrig_d;
  logic [7:0]      tag_q, tag_d;
  logic            overflow_q, overflow_d;
  logic [7:0]      drop_cnt_q, drop_cnt_d;
  logic [7:0]      rej_cnt_q, rej_cnt_d;

  logic full, not_empty, det_event, reject, accept, pop, push, drop;

  // Explicit wrap so non-power-of-2 depths work.
  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(DEPTH - 1)) ? '0 : p + PtrW'(1);
  endfunction

  always_comb begin
    mem_d      = mem_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    level_d    = level_q;
    rtrig_d    = rtrig_q;
    tag_d      = tag_q;
    overflow_d = overflow_q;
    drop_cnt_d = drop_cnt_q;
    rej_cnt_d  = rej_cnt_q;

    full      = (level_q == 4'(DEPTH));
    not_empty = (level_q != 4'd0);
    det_event = itrigger & ~rtrig_q & erx_en;
    reject    = det_event & (ipeak <= MIN_PEAK);
    accept    = det_event & ~reject;
    pop       = not_empty & iready & erx_en;
    push      = accept & (~full | pop);
    drop      = accept & ~push;

    if (!erx_en) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      level_d  = 4'd0;
      rtrig_d  = 1'b0;
      tag_d    = 8'd0;
    end else begin
      rtrig_d = itrigger;
      if (accept) tag_d = tag_q + 8'd1;
      if (push) begin
        mem_d[wr_ptr_q] = '{peak: ipeak, seq: iseq, tim: itime, tag: tag_q};
        wr_ptr_d        = ptr_inc(wr_ptr_q);
      end
      if (pop) rd_ptr_d = ptr_inc(rd_ptr_q);
      if (push && !pop)      level_d = level_q + 4'd1;
      else if (pop && !push) level_d = level_q - 4'd1;
    end

    // Clear takes priority over a same-cycle drop or reject.
    if (iclear_status) begin
      overflow_d = 1'b0;
      drop_cnt_d = 8'd0;
      rej_cnt_d  = 8'd0;
    end else begin
      if (drop) begin
        overflow_d = 1'b1;
        if (drop_cnt_q != 8'hff) drop_cnt_d = drop_cnt_q + 8'd1;
      end
      if (reject && rej_cnt_q != 8'hff) rej_cnt_d = rej_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge crx_clk or negedge rrx_rst_n) begin
    if (!rrx_rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      level_q    <= 4'd0;
      rtrig_q    <= 1'b0;
      tag_q      <= 8'd0;
      overflow_q <= 1'b0;
      drop_cnt_q <= 8'd0;
      rej_cnt_q  <= 8'd0;
    end else begin
      mem_q      <= mem_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      level_q    <= level_d;
      rtrig_q    <= rtrig_d;
      tag_q      <= tag_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
      rej_cnt_q  <= rej_cnt_d;
    end
  end

  assign o_valid        = (level_q != 4'd0);
  assign o_peak         = mem_q[rd_ptr_q].peak;
  assign o_seq          = mem_q[rd_ptr_q].seq;
  assign o_time         = mem_q[rd_ptr_q].tim;
  assign o_tag          = mem_q[rd_ptr_q].tag;
  assign o_level        = level_q;
  assign o_overflow     = overflow_q;
  assign o_drop_count   = drop_cnt_q;
  assign o_reject_count = rej_cnt_q;

endmodule

// File: tb/tb_rx_detection_report_fifo.sv
// Directed bench for rx_detection_report_fifo (DEPTH=4, MIN_PEAK=500).
module tb_rx_detection_report_fifo;

  logic               crx_clk = 1'b0;
  logic               rrx_rst_n;
  logic               erx_en;
  logic signed [40:0] ipeak;
  logic        [3:0]  iseq;
  logic        [15:0] itime;
  logic               itrigger;
  logic               iready;
  logic               iclear_status;
  logic               o_valid;
  logic signed [40:0] o_peak;
  logic        [3:0]  o_seq;
  logic        [15:0] o_time;
  logic        [7:0]  o_tag;
  logic        [3:0]  o_level;
  logic               o_overflow;
  logic        [7:0]  o_drop_count;
  logic        [7:0]  o_reject_count;

  int passed = 0;
  int total  = 0;

  rx_detection_report_fifo #(
    .DEPTH   (4),
    .MIN_PEAK(41'sd500)
  ) dut (
    .crx_clk       (crx_clk),
    .rrx_rst_n     (rrx_rst_n),
    .erx_en        (erx_en),
    .ipeak         (ipeak),
    .iseq          (iseq),
    .itime         (itime),
    .itrigger      (itrigger),
    .iready        (iready),
    .iclear_status (iclear_status),
    .o_valid       (o_valid),
    .o_peak        (o_peak),
    .o_seq         (o_seq),
    .o_time        (o_time),
    .o_tag         (o_tag),
    .o_level       (o_level),
    .o_overflow    (o_overflow),
    .o_drop_count  (o_drop_count),
    .o_reject_count(o_reject_count)
  );

  always #5 crx_clk = ~crx_clk;

  typedef struct {
    logic               trig;
    logic signed [40:0] peak;
    logic               rdy;
    logic               clr;
    logic               ev;
    logic [3:0]         elvl;
    logic [7:0]         etag;
    logic               eovf;
    logic [7:0]         edrop;
    logic [7:0]         erej;
  } vec_t;

  localparam int NV = 32;
  vec_t tbl [NV];

  function automatic vec_t mk(input logic t, input int pk, input logic r, input logic c,
                              input logic v, input int lvl, input int tg, input logic ov,
                              input int dr, input int rj);
    vec_t x;
    x.trig = t;  x.peak = 41'(pk); x.rdy = r; x.clr = c;
    x.ev = v;    x.elvl = 4'(lvl); x.etag = 8'(tg);
    x.eovf = ov; x.edrop = 8'(dr); x.erej = 8'(rj);
    return x;
  endfunction

  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  // Drive at the falling edge, sample 1ns after the following rising edge.
  task automatic step(input logic t, input int pk, input logic r, input logic c, input logic en);
    @(negedge crx_clk);
    itrigger = t; ipeak = 41'(pk); iready = r; iclear_status = c; erx_en = en;
    @(posedge crx_clk);
    #1;
  endtask

  initial begin
    // Rows: trig peak rdy clr | valid level headtag ovf drop rej
    tbl[0]  = mk(1, 500, 0, 0, 0, 0, 0, 0, 0, 1);  // boundary: equal is rejected
    tbl[1]  = mk(0, 600, 0, 0, 0, 0, 0, 0, 0, 1);
    tbl[2]  = mk(1, -3,  0, 0, 0, 0, 0, 0, 0, 2);
    tbl[3]  = mk(0, 600, 0, 0, 0, 0, 0, 0, 0, 2);
    tbl[4]  = mk(1, 501, 0, 0, 1, 1, 0, 0, 0, 2);
    tbl[5]  = mk(0, 600, 0, 0, 1, 1, 0, 0, 0, 2);
    tbl[6]  = mk(1, 600, 0, 0, 1, 2, 0, 0, 0, 2);
    tbl[7]  = mk(0, 600, 0, 0, 1, 2, 0, 0, 0, 2);
    tbl[8]  = mk(1, 600, 0, 0, 1, 3, 0, 0, 0, 2);
    tbl[9]  = mk(0, 600, 0, 0, 1, 3, 0, 0, 0, 2);
    tbl[10] = mk(1, 600, 0, 0, 1, 4, 0, 0, 0, 2);
    tbl[11] = mk(0, 600, 0, 0, 1, 4, 0, 0, 0, 2);
    tbl[12] = mk(1, 600, 0, 0, 1, 4, 0, 1, 1, 2);  // drop tag 4
    tbl[13] = mk(0, 600, 0, 0, 1, 4, 0, 1, 1, 2);
    tbl[14] = mk(1, 600, 0, 0, 1, 4, 0, 1, 2, 2);  // drop tag 5
    tbl[15] = mk(0, 600, 1, 0, 1, 3, 1, 1, 2, 2);
    tbl[16] = mk(0, 600, 1, 0, 1, 2, 2, 1, 2, 2);
    tbl[17] = mk(0, 600, 1, 0, 1, 1, 3, 1, 2, 2);
    tbl[18] = mk(1, 600, 0, 0, 1, 2, 3, 1, 2, 2);  // tag 6 stored
    tbl[19] = mk(0, 600, 1, 0, 1, 1, 6, 1, 2, 2);
    tbl[20] = mk(1, 600, 0, 0, 1, 2, 6, 1, 2, 2);  // tag 7
    tbl[21] = mk(0, 600, 0, 0, 1, 2, 6, 1, 2, 2);
    tbl[22] = mk(1, 600, 0, 0, 1, 3, 6, 1, 2, 2);  // tag 8
    tbl[23] = mk(0, 600, 0, 0, 1, 3, 6, 1, 2, 2);
    tbl[24] = mk(1, 600, 0, 0, 1, 4, 6, 1, 2, 2);  // tag 9, full
    tbl[25] = mk(0, 600, 0, 0, 1, 4, 6, 1, 2, 2);
    tbl[26] = mk(1, 600, 1, 0, 1, 4, 7, 1, 2, 2);  // full push+pop, tag 10
    tbl[27] = mk(0, 600, 0, 1, 1, 4, 7, 0, 0, 0);  // clear
    tbl[28] = mk(1, 600, 0, 1, 1, 4, 7, 0, 0, 0);  // drop tag 11, clear wins
    tbl[29] = mk(0, 600, 0, 0, 1, 4, 7, 0, 0, 0);
    tbl[30] = mk(1, 100, 0, 1, 1, 4, 7, 0, 0, 0);  // reject, clear wins
    tbl[31] = mk(0, 600, 1, 0, 1, 3, 8, 0, 0, 0);

    rrx_rst_n = 1'b0; erx_en = 1'b0; ipeak = '0; iseq = 4'd5; itime = 16'h1234;
    itrigger = 1'b0; iready = 1'b0; iclear_status = 1'b0;
    #12;
    chk("rst valid", o_valid, 0);
    chk("rst level", o_level, 0);
    chk("rst peak", o_peak, 0);
    chk("rst tag", o_tag, 0);
    chk("rst ovf", o_overflow, 0);
    chk("rst drop", o_drop_count, 0);
    chk("rst rej", o_reject_count, 0);
    @(negedge crx_clk);
    rrx_rst_n = 1'b1;
    step(0, 0, 0, 0, 1);

    // First detection lands one edge later.
    step(1, 1000, 0, 0, 1);
    chk("t1 valid", o_valid, 1);
    chk("t1 peak", o_peak, 1000);
    chk("t1 seq", o_seq, 5);
    chk("t1 time", o_time, 16'h1234);
    chk("t1 tag", o_tag, 0);
    chk("t1 level", o_level, 1);

    // Held trigger: one event only.
    for (int i = 0; i < 49; i++) step(1, 1000, 0, 0, 1);
    chk("t2 level", o_level, 1);
    chk("t2 tag", o_tag, 0);
    step(0, 1000, 1, 0, 1);
    chk("t2 pop level", o_level, 0);
    chk("t2 pop valid", o_valid, 0);
    step(1, 1000, 0, 0, 1);
    chk("t2 next tag", o_tag, 1);
    chk("t2 next valid", o_valid, 1);

    step(0, 0, 0, 0, 0);
    chk("flush0 valid", o_valid, 0);
    chk("flush0 level", o_level, 0);

    for (int i = 0; i < NV; i++) begin
      step(tbl[i].trig, int'(tbl[i].peak), tbl[i].rdy, tbl[i].clr, 1'b1);
      chk($sformatf("r%0d valid", i), o_valid, tbl[i].ev);
      chk($sformatf("r%0d level", i), o_level, tbl[i].elvl);
      if (tbl[i].ev) chk($sformatf("r%0d tag", i), o_tag, tbl[i].etag);
      chk($sformatf("r%0d ovf", i), o_overflow, tbl[i].eovf);
      chk($sformatf("r%0d drop", i), o_drop_count, tbl[i].edrop);
      chk($sformatf("r%0d rej", i), o_reject_count, tbl[i].erej);
    end

    // Reject counter saturates at 255.
    for (int i = 0; i < 260; i++) begin
      step(1, 0, 0, 0, 1);
      step(0, 0, 0, 0, 1);
    end
    chk("sat rej", o_reject_count, 255);
    chk("sat level", o_level, 3);

    // Flush empties the FIFO, keeps status, resets the tag.
    step(0, 0, 0, 0, 0);
    chk("flush valid", o_valid, 0);
    chk("flush level", o_level, 0);
    chk("flush rej", o_reject_count, 255);
    step(1, 700, 0, 0, 1);
    chk("post flush tag", o_tag, 0);
    chk("post flush peak", o_peak, 700);
    chk("post flush level", o_level, 1);
    step(0, 700, 0, 0, 1);
    step(1, 800, 0, 0, 1);
    chk("pre rst level", o_level, 2);

    // Async reset in the middle of a pop.
    @(negedge crx_clk);
    itrigger = 1'b0; iready = 1'b1;
    #2 rrx_rst_n = 1'b0;
    #1;
    chk("arst valid", o_valid, 0);
    chk("arst level", o_level, 0);
    chk("arst peak", o_peak, 0);
    chk("arst tag", o_tag, 0);
    chk("arst rej", o_reject_count, 0);
    chk("arst time", o_time, 0);
    @(negedge crx_clk);
    rrx_rst_n = 1'b1;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
